// File: rtl/aw_vpu_pkg.sv
// Shared VPU constants: source geometry, picture window and scanout fetch FSM encoding.
package aw_vpu_pkg;

    localparam int SRC_W      = 320;
    localparam int SRC_H      = 200;
    localparam int VTOP       = 40;
    localparam int FB_WORDS   = SRC_W * SRC_H / 4;
    localparam int LINE_WORDS = SRC_W / 4;
    localparam int WORD_AW    = $clog2(LINE_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Nibble 0 is the leftmost pixel, held in the top bits of the word.
    function automatic logic [3:0] word_nibble(input logic [15:0] word, input logic [1:0] sel);
        logic [3:0] nib;
        case (sel)
            2'd0:    nib = word[15:12];
            2'd1:    nib = word[11:8];
            2'd2:    nib = word[7:4];
            default: nib = word[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/aw_line_ram.sv
// Ping-pong line buffer: two banks of one source line each, one write port and a
// registered read port. Contents are never cleared.
module aw_line_ram
    import aw_vpu_pkg::*;
(
    input  logic               clk,
    input  logic               wr_en,
    input  logic               wr_bank,
    input  logic [WORD_AW-1:0] wr_word,
    input  logic [15:0]        wr_data,
    input  logic               rd_bank,
    input  logic [WORD_AW-1:0] rd_word,
    output logic [15:0]        rd_data
);

    logic [15:0] mem_q [2][LINE_WORDS];
    logic [15:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank][wr_word] <= wr_data;
        end
        rd_data_q <= mem_q[rd_bank][rd_word];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/aw_scanout_fetch.sv
// Framebuffer scanout: fetches 320x200 4bpp lines into a ping-pong buffer and emits
// pixel- and line-doubled palette indices centred in the 640x480 display.
//
// state   | meaning
// IDLE    | waiting for a line fetch trigger
// REQ     | mem_req high, one word outstanding at a time
// DONE    | line complete, marks its bank ready
module aw_scanout_fetch
    import aw_vpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    input  logic [1:0]  fb_sel,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  pix_index,
    output logic        pix_valid,
    output logic        underrun
);

    localparam logic [9:0]         V_FETCH0     = 10'(VTOP - 2);
    localparam logic [9:0]         V_TOP        = 10'(VTOP);
    localparam logic [9:0]         V_LINES      = 10'(2 * SRC_H);
    localparam logic [9:0]         H_PIX        = 10'(2 * SRC_W);
    localparam logic [9:0]         H_LAST_RD    = 10'(2 * SRC_W - 1);
    localparam logic [WORD_AW-1:0] W_LAST       = WORD_AW'(LINE_WORDS - 1);
    localparam logic [15:0]        FB_WORDS16   = 16'(FB_WORDS);
    localparam logic [15:0]        LINE_WORDS16 = 16'(LINE_WORDS);

    logic [1:0]         state_q, state_d;
    logic [WORD_AW-1:0] w_q, w_d;
    logic               bank_q, bank_d;
    logic [1:0]         frame_sel_q, frame_sel_d;
    logic               mem_req_q, mem_req_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [1:0]         done_bank_q, done_bank_d;
    logic               underrun_q, underrun_d;
    logic               blank_q, blank_d;
    logic [3:0]         pix_index_q, pix_index_d;
    logic               pix_valid_q, pix_valid_d;

    logic [9:0]         vrel_fetch;
    logic [9:0]         vrel_disp;
    logic               trig;
    logic [7:0]         trig_k;
    logic [1:0]         sel_eff;
    logic [15:0]        line_base;
    logic               in_win;
    logic               line_start;
    logic               blank_now;
    logic               ram_we;
    logic               rd_bank;
    logic [WORD_AW-1:0] rd_word;
    logic [15:0]        ram_rdata;

    // Rows above the window wrap to large values, so one unsigned compare bounds both ends.
    assign vrel_fetch = vpos - V_FETCH0;
    assign trig       = (hpos == '0) && (vrel_fetch < V_LINES) && !vrel_fetch[0];
    assign trig_k     = vrel_fetch[8:1];
    assign sel_eff    = (trig_k == '0) ? fb_sel : frame_sel_q;
    assign line_base  = {14'd0, sel_eff} * FB_WORDS16 + {8'd0, trig_k} * LINE_WORDS16;

    assign vrel_disp  = vpos - V_TOP;
    assign in_win     = vrel_disp < V_LINES;
    assign line_start = (hpos == '0) && in_win && !vrel_disp[0];
    assign blank_now  = line_start ? !done_bank_q[vrel_disp[1]] : blank_q;
    assign ram_we     = (state_q == ST_REQ) && mem_ack;

    // Read one pixel ahead; past the last picture pixel, prefetch word 0 of the next row.
    always_comb begin
        rd_word = '0;
        rd_bank = vrel_disp[1] ^ vrel_disp[0];
        if (hpos < H_LAST_RD) begin
            rd_word = WORD_AW'(hpos[9:3]) + WORD_AW'(&hpos[2:0]);
            rd_bank = vrel_disp[1];
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        bank_d      = bank_q;
        frame_sel_d = frame_sel_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        done_bank_d = done_bank_q;
        underrun_d  = underrun_q;

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d              = ST_REQ;
                    w_d                  = '0;
                    bank_d               = trig_k[0];
                    mem_req_d            = 1'b1;
                    mem_addr_d           = line_base;
                    done_bank_d[trig_k[0]] = 1'b0;
                    if (trig_k == '0) begin
                        frame_sel_d = fb_sel;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (w_q == W_LAST) begin
                        state_d   = ST_DONE;
                        mem_req_d = 1'b0;
                    end else begin
                        w_d        = w_q + 1'b1;
                        mem_addr_d = mem_addr_q + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d             = ST_IDLE;
                done_bank_d[bank_q] = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (trig && (state_q != ST_IDLE)) begin
            underrun_d = 1'b1;
        end
        if (line_start && !done_bank_q[vrel_disp[1]]) begin
            underrun_d = 1'b1;
        end

        blank_d     = blank_now;
        pix_valid_d = display_on && (hpos < H_PIX) && in_win;
        pix_index_d = (pix_valid_d && !blank_now) ? word_nibble(ram_rdata, hpos[2:1]) : 4'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            bank_q      <= 1'b0;
            frame_sel_q <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 16'd0;
            done_bank_q <= 2'b00;
            underrun_q  <= 1'b0;
            blank_q     <= 1'b0;
            pix_index_q <= 4'd0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            bank_q      <= bank_d;
            frame_sel_q <= frame_sel_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            done_bank_q <= done_bank_d;
            underrun_q  <= underrun_d;
            blank_q     <= blank_d;
            pix_index_q <= pix_index_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    aw_line_ram u_line_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_bank (bank_q),
        .wr_word (w_q),
        .wr_data (mem_rdata),
        .rd_bank (rd_bank),
        .rd_word (rd_word),
        .rd_data (ram_rdata)
    );

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign pix_index = pix_index_q;
    assign pix_valid = pix_valid_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_aw_scanout_fetch.sv
// Directed bench for aw_scanout_fetch: memory echoes the address as data, so every
// pixel is predictable from the framebuffer base, source line and pixel position.
module tb_aw_scanout_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        display_on;
    logic [1:0]  fb_sel;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [3:0]  pix_index;
    logic        pix_valid;
    logic        underrun;

    int n_chk = 0;
    int n_err = 0;

    // 0: ack same cycle, 1: ack 3 cycles after req, 2: ack stuck low, 3: ack stuck high
    int          mode = 3;
    logic [1:0]  dly_cnt = 2'd0;
    int          exp_base = 32000;

    int          acked[$];
    int          req_cyc = 0;
    int          stab_err = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_addr = 16'd0;

    typedef struct {
        int         h;
        int         v;
        logic [3:0] idx;
        logic       val;
    } vec_t;
    vec_t tbl [15];

    aw_scanout_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .fb_sel     (fb_sel),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pix_index  (pix_index),
        .pix_valid  (pix_valid),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr;
    assign mem_ack   = (mode == 0) ? mem_req :
                       (mode == 1) ? (mem_req && dly_cnt == 2'd3) :
                       (mode == 3);

    always @(posedge clk) begin
        if (mode == 1 && mem_req && !mem_ack) dly_cnt <= dly_cnt + 2'd1;
        else                                  dly_cnt <= 2'd0;
    end

    always @(negedge clk) begin
        if (reset) begin
            if (mem_req && mem_ack) acked.push_back(int'(mem_addr));
            if (mem_req) req_cyc++;
            if (mem_req && prev_req && !prev_ack && mem_addr != prev_addr) stab_err++;
        end
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        acked.delete();
        req_cyc  = 0;
        stab_err = 0;
    endtask

    task automatic drive(input int h, input int v);
        @(negedge clk);
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = (h < 640) && (v < 480);
    endtask

    function automatic void exp_pix(input int h, input int v, input bit blank,
                                    output logic [3:0] idx, output logic val);
        int s, w, nib;
        val = (h < 640) && (v >= 40) && (v < 440);
        idx = 4'd0;
        if (val && !blank) begin
            s   = (v - 40) / 2;
            w   = exp_base + s * 80 + h / 8;
            nib = (h / 2) % 4;
            idx = 4'((w >> (12 - 4 * nib)) & 15);
        end
    endfunction

    task automatic run_line(input int v, input bit chk, input bit blank);
        int         bad = 0;
        string      first = "";
        logic [3:0] ei;
        logic       ev;
        for (int h = 0; h < 800; h++) begin
            @(negedge clk);
            if (chk && h > 0) begin
                exp_pix(h - 1, v, blank, ei, ev);
                if (pix_index !== ei || pix_valid !== ev) begin
                    if (bad == 0)
                        first = $sformatf("hpos=%0d got idx=%0d valid=%0d, expected idx=%0d valid=%0d",
                                          h - 1, pix_index, pix_valid, ei, ev);
                    bad++;
                end
            end
            hpos       = 10'(h);
            vpos       = 10'(v);
            display_on = (h < 640) && (v < 480);
        end
        if (chk) begin
            n_chk++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL line%0d_pixels: %0d wrong pixels, first at %s", v, bad, first);
            end
        end
    endtask

    task automatic check_acks(input string name, input int base);
        int bad = 0;
        check({name, "_count"}, acked.size(), 80);
        foreach (acked[i]) if (acked[i] != base + i) bad++;
        check({name, "_order"}, bad, 0);
        check({name, "_first"}, (acked.size() > 0) ? acked[0] : -1, base);
    endtask

    initial begin
        logic found;

        tbl[0]  = '{2,   40,  4'hD, 1'b1};
        tbl[1]  = '{3,   40,  4'hD, 1'b1};
        tbl[2]  = '{8,   40,  4'h7, 1'b1};
        tbl[3]  = '{15,  40,  4'h1, 1'b1};
        tbl[4]  = '{16,  40,  4'h7, 1'b1};
        tbl[5]  = '{639, 40,  4'hF, 1'b1};
        tbl[6]  = '{640, 40,  4'h0, 1'b0};
        tbl[7]  = '{4,   41,  4'h0, 1'b1};
        tbl[8]  = '{15,  41,  4'h1, 1'b1};
        tbl[9]  = '{2,   42,  4'hD, 1'b1};
        tbl[10] = '{12,  42,  4'h5, 1'b1};
        tbl[11] = '{639, 43,  4'hF, 1'b1};
        tbl[12] = '{4,   439, 4'h5, 1'b1};
        tbl[13] = '{4,   440, 4'h0, 1'b0};
        tbl[14] = '{4,   39,  4'h0, 1'b0};

        reset      = 1'b0;
        hpos       = 10'd0;
        vpos       = 10'd0;
        display_on = 1'b0;
        fb_sel     = 2'd2;

        // Reset held with ack forced high
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_mem_req", mem_req, 1'b0);
            check("rst_pix_valid", pix_valid, 1'b0);
            check("rst_underrun", underrun, 1'b0);
        end
        check("rst_mem_addr", mem_addr, 16'd0);
        check("rst_pix_index", pix_index, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        mode  = 0;

        // Line 0 fetch from framebuffer 2, zero-latency memory
        exp_base = 32000;
        clear_mon();
        run_line(38, 1'b1, 1'b0);
        check_acks("line0_fetch", 32000);
        check("line0_req_cycles", req_cyc, 80);
        run_line(39, 1'b1, 1'b0);
        run_line(40, 1'b1, 1'b0);
        run_line(41, 1'b1, 1'b0);

        // Spot vectors across the window boundaries and line doubling
        foreach (tbl[i]) begin
            drive(tbl[i].h - 1, tbl[i].v);
            drive(tbl[i].h, tbl[i].v);
            @(negedge clk);
            check($sformatf("vec%0d_idx", i), pix_index, tbl[i].idx);
            check($sformatf("vec%0d_valid", i), pix_valid, tbl[i].val);
        end

        run_line(42, 1'b1, 1'b0);
        run_line(43, 1'b1, 1'b0);
        check("underrun_after_line43", underrun, 1'b0);

        // Slow memory: ack three cycles after each request
        mode = 1;
        clear_mon();
        run_line(44, 1'b1, 1'b0);
        check_acks("slow_fetch", 32240);
        check("slow_req_cycles", req_cyc, 320);
        run_line(45, 1'b1, 1'b0);
        run_line(46, 1'b1, 1'b0);
        run_line(47, 1'b1, 1'b0);
        check("slow_addr_stable", stab_err, 0);
        check("slow_underrun", underrun, 1'b0);

        // Memory stalls once line 5 fetch starts
        mode = 2;
        run_line(48, 1'b1, 1'b0);
        run_line(49, 1'b1, 1'b0);
        check("underrun_before_line50", underrun, 1'b0);
        run_line(50, 1'b1, 1'b1);
        check("underrun_set_line50", underrun, 1'b1);
        mode = 0;
        run_line(51, 1'b1, 1'b1);
        check("underrun_sticky", underrun, 1'b1);
        check("stalled_fetch_finished", mem_req, 1'b0);

        // Reset in the middle of a fetch from framebuffer 1
        fb_sel = 2'd1;
        found  = 1'b0;
        for (int h = 0; h < 200 && !found; h++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'd16030) begin
                reset = 1'b0;
                found = 1'b1;
            end else begin
                hpos       = 10'(h);
                vpos       = 10'd38;
                display_on = 1'b0;
            end
        end
        #1;
        check("midfetch_word30_reached", found, 1'b1);
        check("midfetch_req_async_drop", mem_req, 1'b0);
        check("midfetch_addr_reset", mem_addr, 16'd0);
        check("midfetch_underrun_reset", underrun, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        exp_base = 16000;
        clear_mon();
        run_line(38, 1'b1, 1'b0);
        check_acks("refetch", 16000);
        fb_sel = 2'd3;
        run_line(39, 1'b1, 1'b0);
        clear_mon();
        run_line(40, 1'b1, 1'b0);
        check_acks("fbsel_ignored_midframe", 16080);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
